// File: rtl/fp_convert_arbiter_if.sv
// Handshake bundle between the two sample requesters, the shared
// 12-bit -> 8-bit float converter and the result consumer.
// FP_SAT_FLAG_EN adds the out_sat result flag.
interface fp_convert_arbiter_if;
  logic        req0_valid;
  logic [11:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [11:0] req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_id;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
`ifdef FP_SAT_FLAG_EN
  logic        out_sat;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_s, out_e, out_f,
           out_sat
  );
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_s, out_e, out_f,
           out_sat
  );
`else
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_id, out_s, out_e, out_f
  );
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_id, out_s, out_e, out_f
  );
`endif
endinterface

// File: rtl/fp_convert_arbiter.sv
// Shared iterative converter: 12-bit two's complement -> (S, E[2:0], F[3:0]),
// value = (-1)^S * F * 2^E. Two requesters, round-robin (or fixed priority
// with PRIO_FIXED=1). Sequence per sample: ABS, NORM (one shift per cycle),
// RND, then DONE holds the result until the consumer takes it.
// Optional feature macro: FP_SAT_FLAG_EN adds the out_sat result flag.
module fp_convert_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_convert_arbiter_if.slave  bus,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_RND,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_last;      // requester granted last; reset to 1 so req0 wins first
  logic        r_id;
  logic [11:0] r_data;
  logic        r_s;
  logic [11:0] r_w;
  logic [3:0]  r_e;
  logic        r_out_valid;
  logic        r_out_id;
  logic        r_out_s;
  logic [2:0]  r_out_e;
  logic [3:0]  r_out_f;
`ifdef FP_SAT_FLAG_EN
  logic        r_in_sat;
  logic        r_out_sat;
`endif

  logic        w_gnt1;
  logic        w_accept;
  logic [11:0] w_mag;
  logic [11:0] w_w_sh;
  logic [3:0]  w_e_dec;
  logic        w_norm_done;
  logic [4:0]  w_f_sum;
  logic [2:0]  w_rnd_e;
  logic [3:0]  w_rnd_f;
  logic        w_rnd_sat;

  // Arbitration: pick which valid requester is granted while IDLE.
  always_comb begin
    w_gnt1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      w_gnt1 = PRIO_FIXED ? 1'b0 : ~r_last;
    else
      w_gnt1 = bus.req1_valid;
  end

  // Transfer only in IDLE, and never while reset is being applied.
  assign w_accept       = (r_state == S_IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = w_accept && !w_gnt1;
  assign bus.req1_ready = w_accept &&  w_gnt1;

  // Magnitude; -2048 has no positive 12-bit counterpart so it clamps to 2047.
  always_comb begin
    w_mag = r_data;
    if (r_data == 12'h800)
      w_mag = 12'h7FF;
    else if (r_data[11])
      w_mag = 12'(~r_data + 12'd1);
  end

  // One normalisation step; leave NORM once the MSB is set or E has hit zero.
  always_comb begin
    w_w_sh      = {r_w[10:0], 1'b0};
    w_e_dec     = r_e - 4'd1;
    w_norm_done = (w_e_dec == 4'd0) || w_w_sh[11];
  end

  // Round half-up on w[7]; significand overflow bumps E, E overflow saturates.
  // E is at most 7 here because NORM always performs at least one shift.
  always_comb begin
    w_f_sum   = {1'b0, r_w[11:8]} + {4'b0000, r_w[7]};
    w_rnd_e   = r_e[2:0];
    w_rnd_f   = w_f_sum[3:0];
    w_rnd_sat = 1'b0;
    if (w_f_sum[4]) begin
      if (r_e[2:0] == 3'd7) begin
        w_rnd_e   = 3'd7;
        w_rnd_f   = 4'd15;
        w_rnd_sat = 1'b1;
      end else begin
        w_rnd_e = r_e[2:0] + 3'd1;
        w_rnd_f = 4'b1000;
      end
    end
  end

  // Sequencer with registered outputs; reset drops any in-flight sample.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_data      <= '0;
      r_s         <= 1'b0;
      r_w         <= '0;
      r_e         <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= 1'b0;
      r_out_s     <= 1'b0;
      r_out_e     <= '0;
      r_out_f     <= '0;
`ifdef FP_SAT_FLAG_EN
      r_in_sat    <= 1'b0;
      r_out_sat   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data  <= w_gnt1 ? bus.req1_data : bus.req0_data;
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_state <= S_ABS;
          end
        end
        S_ABS: begin
          r_s     <= r_data[11];
          r_w     <= w_mag;
          r_e     <= 4'd8;
`ifdef FP_SAT_FLAG_EN
          r_in_sat <= (r_data == 12'h800);
`endif
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_w <= w_w_sh;
          r_e <= w_e_dec;
          if (w_norm_done)
            r_state <= S_RND;
        end
        S_RND: begin
          r_out_valid <= 1'b1;
          r_out_id    <= r_id;
          r_out_s     <= r_s;
          r_out_e     <= w_rnd_e;
          r_out_f     <= w_rnd_f;
`ifdef FP_SAT_FLAG_EN
          r_out_sat   <= r_in_sat | w_rnd_sat;
`endif
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_id    = r_out_id;
  assign bus.out_s     = r_out_s;
  assign bus.out_e     = r_out_e;
  assign bus.out_f     = r_out_f;
`ifdef FP_SAT_FLAG_EN
  assign bus.out_sat   = r_out_sat;
`endif
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_convert_arbiter.sv
// Directed bench for fp_convert_arbiter (PRIO_FIXED=0). Inputs change and
// outputs are sampled on the falling edge. Latency is counted in rising
// edges with the accept edge as edge 1.
module tb_fp_convert_arbiter;

  logic clk;
  logic rst;
  logic busy;
  int   n_cmp;
  int   n_err;

  fp_convert_arbiter_if bus ();

  fp_convert_arbiter #(.PRIO_FIXED(1'b0)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for out_valid; call at the negedge after the accept edge.
  task automatic wait_out(output int n);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // Take the result and confirm the block returns to idle.
  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL %s drain: valid,busy=%b expected 00", name, {bus.out_valid, busy});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, busy, bus.out_id, bus.out_s, bus.out_e, bus.out_f} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected 0", {bus.out_valid, busy, bus.out_id,
               bus.out_s, bus.out_e, bus.out_f});
    end
`ifdef FP_SAT_FLAG_EN
    n_cmp++;
    if (bus.out_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sat: got %b expected 0", bus.out_sat);
    end
`endif
    rst = 1'b0;
  endtask

  // One conversion from a single requester with expected result and latency.
  task automatic run_conv(input string name, input bit id, input logic [11:0] d,
                          input int exp_n, input logic [7:0] exp_sef, input bit exp_sat);
    int n;
    @(negedge clk);
    if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    else    begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    #1;
    n_cmp++;
    if ({bus.req1_ready, bus.req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      n_err++;
      $display("FAIL %s ready: got %b", name, {bus.req1_ready, bus.req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_out(n);
    n_cmp++;
    if (!bus.out_valid || n !== exp_n) begin
      n_err++;
      $display("FAIL %s latency: got %0d edges (valid=%b) expected %0d", name, n,
               bus.out_valid, exp_n);
    end
    n_cmp++;
    if ({bus.out_id, bus.out_s, bus.out_e, bus.out_f, busy} !== {id, exp_sef, 1'b1}) begin
      n_err++;
      $display("FAIL %s result: id=%b s=%b e=%0d f=%0d busy=%b expected id=%b s=%b e=%0d f=%0d busy=1",
               name, bus.out_id, bus.out_s, bus.out_e, bus.out_f, busy,
               id, exp_sef[7], exp_sef[6:4], exp_sef[3:0]);
    end
`ifdef FP_SAT_FLAG_EN
    n_cmp++;
    if (bus.out_sat !== exp_sat) begin
      n_err++;
      $display("FAIL %s sat: got %b expected %b", name, bus.out_sat, exp_sat);
    end
`else
    if (exp_sat) begin end
`endif
    drain(name);
  endtask

  task automatic test_conversions();
    //        name         id  data     edges  {S,E,F}              sat
    run_conv("zero",      0, 12'h000,  11, {1'b0, 3'd0, 4'd0},  1'b0);
    run_conv("p422",      1, 12'd422,   6, {1'b0, 3'd5, 4'd13}, 1'b0);
    run_conv("p47_round", 0, 12'd47,    9, {1'b0, 3'd2, 4'd12}, 1'b0);
    run_conv("min_neg",   0, 12'h800,   4, {1'b1, 3'd7, 4'd15}, 1'b1);
    run_conv("neg_one",   1, 12'hFFF,  11, {1'b1, 3'd0, 4'd1},  1'b0);
    run_conv("ovf_e7",    0, 12'h3F8,   5, {1'b0, 3'd7, 4'd8},  1'b0);
    run_conv("max_pos",   1, 12'h7FF,   4, {1'b0, 3'd7, 4'd15}, 1'b1);
    run_conv("n422",      0, 12'hE5A,   6, {1'b1, 3'd5, 4'd13}, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [8:0] snap;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 12'd422;
    bus.req1_valid = 1'b1; bus.req1_data = 12'd47;
    #1;
    n_cmp++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b grant1: ready1,ready0=%b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_data = 12'hE5A;
    wait_out(n);
    n_cmp++;
    if (!bus.out_valid || {bus.out_id, bus.out_s, bus.out_e, bus.out_f} !== {1'b0, 1'b0, 3'd5, 4'd13}) begin
      n_err++;
      $display("FAIL b2b res1: valid=%b id=%b s=%b e=%0d f=%0d expected id=0 s=0 e=5 f=13",
               bus.out_valid, bus.out_id, bus.out_s, bus.out_e, bus.out_f);
    end
    snap = {bus.out_id, bus.out_s, bus.out_e, bus.out_f};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.out_id, bus.out_s, bus.out_e, bus.out_f,
           bus.req1_ready, bus.req0_ready} !== {1'b1, snap, 2'b00}) begin
        n_err++;
        $display("FAIL b2b hold%0d: valid=%b out=%h ready=%b expected valid=1 out=%h ready=00",
                 i, bus.out_valid, {bus.out_id, bus.out_s, bus.out_e, bus.out_f},
                 {bus.req1_ready, bus.req0_ready}, snap);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b grant2: ready1,ready0=%b expected 10", {bus.req1_ready, bus.req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    wait_out(n);
    n_cmp++;
    if (!bus.out_valid || {bus.out_id, bus.out_s, bus.out_e, bus.out_f} !== {1'b1, 1'b0, 3'd2, 4'd12}) begin
      n_err++;
      $display("FAIL b2b res2: valid=%b id=%b s=%b e=%0d f=%0d expected id=1 s=0 e=2 f=12",
               bus.out_valid, bus.out_id, bus.out_s, bus.out_e, bus.out_f);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b grant3: ready1,ready0=%b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_out(n);
    n_cmp++;
    if (!bus.out_valid || {bus.out_id, bus.out_s, bus.out_e, bus.out_f} !== {1'b0, 1'b1, 3'd5, 4'd13}) begin
      n_err++;
      $display("FAIL b2b res3: valid=%b id=%b s=%b e=%0d f=%0d expected id=0 s=1 e=5 f=13",
               bus.out_valid, bus.out_id, bus.out_s, bus.out_e, bus.out_f);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid_norm();
    int n;
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_data  = 12'h000;
    @(posedge clk);              // accept
    @(negedge clk);
    repeat (3) @(posedge clk);   // ABS, then two NORM shifts
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL midrst state: valid,busy=%b expected 00", {bus.out_valid, busy});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst regrant: ready0=%b expected 1", bus.req0_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_out(n);
    n_cmp++;
    if (!bus.out_valid || n !== 11 ||
        {bus.out_id, bus.out_s, bus.out_e, bus.out_f} !== 9'd0) begin
      n_err++;
      $display("FAIL midrst result: valid=%b edges=%0d id=%b s=%b e=%0d f=%0d expected 11 edges, all 0",
               bus.out_valid, n, bus.out_id, bus.out_s, bus.out_e, bus.out_f);
    end
    drain("midrst");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_conversions();
    test_back_to_back();
    test_reset_mid_norm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
